// File: rtl/core_mem_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_mem_bridge_pkg
// Description : Shared state encodings and bus constants for core_mem_bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package core_mem_bridge_pkg;

    // Bridge sequencer state encoding (3-bit state bus)
    localparam int          BRIDGE_STATE_W = 3;
    localparam logic [2:0]  BRIDGE_IDLE    = 3'd0;
    localparam logic [2:0]  D_REQ          = 3'd1;
    localparam logic [2:0]  D_WAIT         = 3'd2;
    localparam logic [2:0]  I_REQ          = 3'd3;
    localparam logic [2:0]  I_WAIT         = 3'd4;
    localparam logic [2:0]  DONE           = 3'd5;

    // Byte-enable pattern meaning "read, no bytes written"
    localparam logic [3:0]  BUS_WE_NONE    = 4'b0000;

endpackage : core_mem_bridge_pkg
`default_nettype wire

// File: rtl/core_mem_bridge_req.sv
`default_nettype none
// ============================================================================
// Module      : bridge_req_reg
// Description : Latches the external request payload on entry to a request
//               state and holds it, with valid asserted, until the bus
//               accepts it (valid & ready).
// Revision    : 1.0 - initial release
// ============================================================================
module bridge_req_reg #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int SEL_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [SEL_W-1:0]  we_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic              fire_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [SEL_W-1:0]  we_o,
    output logic [DATA_W-1:0] wdata_o
);

    logic              valid_q;
    logic [ADDR_W-1:0] addr_q;
    logic [SEL_W-1:0]  we_q;
    logic [DATA_W-1:0] wdata_q;

    // Payload is captured once and held; valid only drops on a handshake
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            we_q    <= '0;
            wdata_q <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            addr_q  <= addr_i;
            we_q    <= we_i;
            wdata_q <= wdata_i;
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign fire_o  = valid_q & ready_i;
    assign addr_o  = addr_q;
    assign we_o    = we_q;
    assign wdata_o = wdata_q;

endmodule : bridge_req_reg
`default_nettype wire

// File: rtl/core_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module      : core_mem_bridge
// Description : Serialises the core's data access and instruction fetch onto
//               one valid/ready memory bus, stalling the core until both
//               complete and presenting read data in the single DONE cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module core_mem_bridge
    import core_mem_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int SEL_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rom_en,
    input  logic [ADDR_W-1:0] rom_addr,
    output logic [DATA_W-1:0] rom_read_data,
    input  logic              ram_en,
    input  logic [SEL_W-1:0]  ram_write_en,
    input  logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_write_data,
    output logic [DATA_W-1:0] ram_read_data,
    output logic              stall,
    output logic              bus_req_valid,
    input  logic              bus_req_ready,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [SEL_W-1:0]  bus_we,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_resp_valid,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic [31:0]       stall_cycles
);

    logic [BRIDGE_STATE_W-1:0] state_q, state_d;
    logic [DATA_W-1:0]         rom_rdata_q, ram_rdata_q;
    logic [31:0]               stall_cycles_q;
    logic                      req_load;
    logic                      req_fire;
    logic [ADDR_W-1:0]         req_addr;
    logic [SEL_W-1:0]          req_we;
    logic [DATA_W-1:0]         req_wdata;

    // Combinational so the core freezes in the very cycle it issues
    assign stall = (rom_en | ram_en) & (state_q != DONE);

    // Next-state sequencing: data access always ahead of the fetch
    always_comb begin
        state_d = state_q;
        case (state_q)
            BRIDGE_IDLE: begin
                if (ram_en)      state_d = D_REQ;
                else if (rom_en) state_d = I_REQ;
            end
            D_REQ:  if (req_fire) state_d = D_WAIT;
            D_WAIT: if (bus_resp_valid) state_d = rom_en ? I_REQ : DONE;
            I_REQ:  if (req_fire) state_d = I_WAIT;
            I_WAIT: if (bus_resp_valid) state_d = DONE;
            DONE:   state_d = BRIDGE_IDLE;
            default: state_d = BRIDGE_IDLE;
        endcase
    end

    // Latch a fresh payload only on the transition into a request state
    always_comb begin
        req_load  = (state_d != state_q) && ((state_d == D_REQ) || (state_d == I_REQ));
        req_addr  = rom_addr;
        req_we    = '0;
        req_wdata = '0;
        if (state_d == D_REQ) begin
            req_addr  = ram_addr;
            req_we    = ram_write_en;
            req_wdata = ram_write_data;
        end
    end

    bridge_req_reg #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .SEL_W  (SEL_W)
    ) u_req (
        .clk     (clk),
        .rst     (rst),
        .load_i  (req_load),
        .addr_i  (req_addr),
        .we_i    (req_we),
        .wdata_i (req_wdata),
        .ready_i (bus_req_ready),
        .valid_o (bus_req_valid),
        .fire_o  (req_fire),
        .addr_o  (bus_addr),
        .we_o    (bus_we),
        .wdata_o (bus_wdata)
    );

    // State register; reset aborts any transaction in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= BRIDGE_IDLE;
        else      state_q <= state_d;
    end

    // Capture read data only in WAIT states; stores leave load data untouched.
    // The held bus_we still reflects the data request while in D_WAIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rom_rdata_q <= '0;
            ram_rdata_q <= '0;
        end else if (bus_resp_valid) begin
            if (state_q == D_WAIT && bus_we == '0) ram_rdata_q <= bus_rdata;
            if (state_q == I_WAIT)                 rom_rdata_q <= bus_rdata;
        end
    end

    // Debug count of stalled cycles, free-running wrap
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       stall_cycles_q <= '0;
        else if (stall) stall_cycles_q <= stall_cycles_q + 32'd1;
    end

    assign rom_read_data = rom_rdata_q;
    assign ram_read_data = ram_rdata_q;
    assign stall_cycles  = stall_cycles_q;

endmodule : core_mem_bridge
`default_nettype wire

// File: tb/tb_core_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_mem_bridge
// Description : Directed self-checking bench for core_mem_bridge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_mem_bridge;
    import core_mem_bridge_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rom_en = 1'b0;
    logic [31:0] rom_addr = '0;
    logic [31:0] rom_read_data;
    logic        ram_en = 1'b0;
    logic [3:0]  ram_write_en = '0;
    logic [31:0] ram_addr = '0;
    logic [31:0] ram_write_data = '0;
    logic [31:0] ram_read_data;
    logic        stall;
    logic        bus_req_valid;
    logic        bus_req_ready = 1'b0;
    logic [31:0] bus_addr;
    logic [3:0]  bus_we;
    logic [31:0] bus_wdata;
    logic        bus_resp_valid = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic [31:0] stall_cycles;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    core_mem_bridge #(.ADDR_W(32), .DATA_W(32), .SEL_W(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .rom_en         (rom_en),
        .rom_addr       (rom_addr),
        .rom_read_data  (rom_read_data),
        .ram_en         (ram_en),
        .ram_write_en   (ram_write_en),
        .ram_addr       (ram_addr),
        .ram_write_data (ram_write_data),
        .ram_read_data  (ram_read_data),
        .stall          (stall),
        .bus_req_valid  (bus_req_valid),
        .bus_req_ready  (bus_req_ready),
        .bus_addr       (bus_addr),
        .bus_we         (bus_we),
        .bus_wdata      (bus_wdata),
        .bus_resp_valid (bus_resp_valid),
        .bus_rdata      (bus_rdata),
        .stall_cycles   (stall_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 1ns after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- reset state ----------------
        rst = 1'b0;
        tick(); tick();
        chk("rst_valid",  {31'd0, bus_req_valid}, 32'd0);
        chk("rst_addr",   bus_addr, 32'd0);
        chk("rst_we",     {28'd0, bus_we}, 32'd0);
        chk("rst_wdata",  bus_wdata, 32'd0);
        chk("rst_romrd",  rom_read_data, 32'd0);
        chk("rst_ramrd",  ram_read_data, 32'd0);
        chk("rst_cnt",    stall_cycles, 32'd0);
        chk("rst_state",  {29'd0, dut.state_q}, {29'd0, BRIDGE_IDLE});
        #3 rst = 1'b1;

        // ---------------- fetch only ----------------
        tick();
        rom_en = 1'b1; rom_addr = 32'hBFC0_0000; bus_req_ready = 1'b1;
        #1 chk("f_stall0", {31'd0, stall}, 32'd1);
        tick();
        #1;
        chk("f_valid",  {31'd0, bus_req_valid}, 32'd1);
        chk("f_addr",   bus_addr, 32'hBFC0_0000);
        chk("f_we",     {28'd0, bus_we}, 32'd0);
        chk("f_stall1", {31'd0, stall}, 32'd1);
        tick();
        bus_resp_valid = 1'b1; bus_rdata = 32'h2401_0001;
        #1;
        chk("f_valid_drop", {31'd0, bus_req_valid}, 32'd0);
        chk("f_stall2",     {31'd0, stall}, 32'd1);
        tick();
        bus_resp_valid = 1'b0; bus_rdata = 32'h0;
        #1;
        chk("f_done_stall", {31'd0, stall}, 32'd0);
        chk("f_rdata",      rom_read_data, 32'h2401_0001);
        chk("f_cnt",        stall_cycles, 32'd3);
        rom_en = 1'b0;
        tick();
        chk("f_idle_state", {29'd0, dut.state_q}, {29'd0, BRIDGE_IDLE});

        // ---------------- load plus fetch ----------------
        ram_en = 1'b1; ram_write_en = 4'b0000; ram_addr = 32'h8000_0010;
        rom_en = 1'b1; rom_addr = 32'hBFC0_0004;
        #1 chk("lf_stall0", {31'd0, stall}, 32'd1);
        tick();
        #1;
        chk("lf_dreq_state", {29'd0, dut.state_q}, {29'd0, D_REQ});
        chk("lf_daddr",      bus_addr, 32'h8000_0010);
        chk("lf_dvalid",     {31'd0, bus_req_valid}, 32'd1);
        tick();
        bus_resp_valid = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        #1 chk("lf_dwait_valid", {31'd0, bus_req_valid}, 32'd0);
        tick();
        bus_resp_valid = 1'b0; bus_rdata = 32'h0;
        #1;
        chk("lf_ivalid",  {31'd0, bus_req_valid}, 32'd1);
        chk("lf_iaddr",   bus_addr, 32'hBFC0_0004);
        chk("lf_ramrd",   ram_read_data, 32'hDEAD_BEEF);
        tick();
        bus_resp_valid = 1'b1; bus_rdata = 32'h8C02_0010;
        #1 chk("lf_stall4", {31'd0, stall}, 32'd1);
        tick();
        bus_resp_valid = 1'b0; bus_rdata = 32'h0;
        #1;
        chk("lf_done_stall", {31'd0, stall}, 32'd0);
        chk("lf_ramrd_done", ram_read_data, 32'hDEAD_BEEF);
        chk("lf_romrd_done", rom_read_data, 32'h8C02_0010);
        chk("lf_cnt",        stall_cycles, 32'd8);
        ram_en = 1'b0; rom_en = 1'b0;
        tick();

        // ---------------- byte store with backpressure ----------------
        bus_req_ready = 1'b0;
        ram_en = 1'b1; ram_write_en = 4'b0010; ram_addr = 32'h8000_0020;
        ram_write_data = 32'h0000_AB00;
        tick();
        // core-side inputs wander; the held bus payload must not
        ram_addr = 32'h1111_1111; ram_write_data = 32'h2222_2222; ram_write_en = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("bp_valid", {31'd0, bus_req_valid}, 32'd1);
            chk("bp_addr",  bus_addr, 32'h8000_0020);
            chk("bp_we",    {28'd0, bus_we}, 32'd2);
            chk("bp_wdata", bus_wdata, 32'h0000_AB00);
            tick();
        end
        ram_addr = 32'h8000_0020; ram_write_data = 32'h0000_AB00; ram_write_en = 4'b0010;
        bus_req_ready = 1'b1;
        #1 chk("bp_valid_last", {31'd0, bus_req_valid}, 32'd1);
        tick();
        bus_resp_valid = 1'b1; bus_rdata = 32'h1234_5678;
        #1 chk("bp_dwait", {29'd0, dut.state_q}, {29'd0, D_WAIT});
        tick();
        bus_resp_valid = 1'b0; bus_rdata = 32'h0;
        #1;
        chk("bp_done_stall", {31'd0, stall}, 32'd0);
        chk("bp_ramrd_kept", ram_read_data, 32'hDEAD_BEEF);
        chk("bp_cnt",        stall_cycles, 32'd15);
        ram_en = 1'b0; ram_write_en = 4'b0000;
        tick();

        // ---------------- reset mid-transaction ----------------
        ram_en = 1'b1; ram_addr = 32'h8000_0030; rom_en = 1'b1; rom_addr = 32'hBFC0_0008;
        tick();
        tick();
        #1 chk("rm_in_dwait", {29'd0, dut.state_q}, {29'd0, D_WAIT});
        #1 rst = 1'b0;
        #1;
        chk("rm_valid", {31'd0, bus_req_valid}, 32'd0);
        chk("rm_state", {29'd0, dut.state_q}, {29'd0, BRIDGE_IDLE});
        chk("rm_cnt",   stall_cycles, 32'd0);
        chk("rm_ramrd", ram_read_data, 32'd0);
        ram_en = 1'b0; rom_en = 1'b0;
        #2 rst = 1'b1;
        tick();
        rom_en = 1'b1; rom_addr = 32'hBFC0_0008;
        tick();
        #1 chk("rm_iaddr", bus_addr, 32'hBFC0_0008);
        tick();
        bus_resp_valid = 1'b1; bus_rdata = 32'h3C1D_8000;
        tick();
        bus_resp_valid = 1'b0; bus_rdata = 32'h0;
        #1;
        chk("rm_f_stall", {31'd0, stall}, 32'd0);
        chk("rm_f_rdata", rom_read_data, 32'h3C1D_8000);
        chk("rm_f_cnt",   stall_cycles, 32'd3);
        rom_en = 1'b0;
        tick();

        // ---------------- counter wrap ----------------
        force dut.stall_cycles_q = 32'hFFFF_FFFE;
        #1 release dut.stall_cycles_q;
        #1 chk("wr_preset", stall_cycles, 32'hFFFF_FFFE);
        tick();
        rom_en = 1'b1; rom_addr = 32'hBFC0_000C;
        tick();
        tick();
        bus_resp_valid = 1'b1; bus_rdata = 32'h0000_0000;
        tick();
        bus_resp_valid = 1'b0;
        #1;
        chk("wr_done_stall", {31'd0, stall}, 32'd0);
        chk("wr_cnt",        stall_cycles, 32'h0000_0001);
        rom_en = 1'b0;
        tick();

        // ---------------- idle ----------------
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("id_stall", {31'd0, stall}, 32'd0);
            chk("id_valid", {31'd0, bus_req_valid}, 32'd0);
        end
        chk("id_cnt", stall_cycles, 32'h0000_0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_core_mem_bridge
`default_nettype wire

// File: doc/core_mem_bridge.md
Name: core_mem_bridge

Overview:
- Sits directly downstream of the core's ROM/RAM ports. It serialises instruction-fetch and data accesses onto one external memory bus that uses a valid/ready request channel and a valid response channel.
- It drives the core's global `stall` input while any access is outstanding. It presents the captured read data on the one cycle the core advances.
- It replaces the zero-wait-state ROM/RAM models with a single variable-latency memory port.

Parameters:
- ADDR_W, 32, address width (matches `ADDR_BUS`).
- DATA_W, 32, data width (matches `DATA_BUS`).
- SEL_W, 4, byte-enable width (matches `MEM_SEL_BUS`).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- rom_en  in  1  core instruction-fetch request.
- rom_addr  in  ADDR_W  fetch address.
- rom_read_data  out  DATA_W  fetched instruction to the core.
- ram_en  in  1  core data-access request.
- ram_write_en  in  SEL_W  byte write enables; zero means read.
- ram_addr  in  ADDR_W  data address.
- ram_write_data  in  DATA_W  store data.
- ram_read_data  out  DATA_W  load data to the core.
- stall  out  1  freeze to the core's pipeline controller.
- bus_req_valid  out  1  request valid.
- bus_req_ready  in  1  request accepted.
- bus_addr  out  ADDR_W  request address.
- bus_we  out  SEL_W  request byte write enables.
- bus_wdata  out  DATA_W  request write data.
- bus_resp_valid  in  1  response (read data or write ack) valid.
- bus_rdata  in  DATA_W  response read data.
- stall_cycles  out  32  count of cycles with stall=1; debug.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, bus_req_valid=0, bus_addr/bus_we/bus_wdata=0.
  - rom_read_data=0, ram_read_data=0, stall_cycles=0.
  - The external bus shares this reset; no response is outstanding after reset deasserts.
- stall = (rom_en | ram_en) & (state != DONE). This is combinational so the core freezes in the same cycle it issues.
- States:
  - IDLE: if ram_en, go to D_REQ; else if rom_en, go to I_REQ; else stay.
  - D_REQ: bus_req_valid=1; bus_addr=ram_addr; bus_we=ram_write_en; bus_wdata=ram_write_data.
    - On bus_req_valid & bus_req_ready, go to D_WAIT.
  - D_WAIT: on bus_resp_valid:
    - if ram_write_en==0, capture bus_rdata into ram_read_data;
    - go to I_REQ if rom_en, else DONE.
  - I_REQ: bus_req_valid=1; bus_addr=rom_addr; bus_we=0; bus_wdata=0.
    - On handshake, go to I_WAIT.
  - I_WAIT: on bus_resp_valid, capture bus_rdata into rom_read_data; go to DONE.
  - DONE: stall=0 for exactly one cycle; the core samples both read-data outputs on the closing edge; go to IDLE.
- Ordering: the data access always precedes the fetch in the same core cycle, so store/load ordering is preserved.
- Request payload stays stable while bus_req_valid=1 and ready=0; the registered copy is latched on entry to the REQ state. bus_req_valid never drops without a handshake.
- Read-data outputs hold their last captured value outside capture events. A write leaves ram_read_data unchanged.
- bus_req_ready and bus_resp_valid in the same cycle as the request:
  - the request handshake is taken;
  - the response is ignored unless the state is a WAIT state;
  - a response cannot precede acceptance.
- Minimum latency with ready=1 and a response one cycle after acceptance:
  - fetch only: 3 stall cycles, then DONE;
  - data plus fetch: 5 stall cycles, then DONE.
- stall_cycles increments by 1 on every cycle with stall=1 and wraps from 0xFFFFFFFF to 0.
- A core request seen in IDLE with both enables low produces no bus activity.
- rst asserted mid-transaction aborts immediately; no partial data is presented.

Decomposition:
- Add to the shared `bus.v` include:
  - state encodings `BRIDGE_IDLE`/`D_REQ`/`D_WAIT`/`I_REQ`/`I_WAIT`/`DONE`, as a 3-bit `BRIDGE_STATE_BUS`;
  - `BUS_WE_NONE` = 4'b0000.
- One natural sub-module: bridge_req_reg, which latches and holds the request payload plus the valid/ready handshake. All other logic stays in core_mem_bridge.

Test Plan:
- Fetch only:
  - Stimulus: rom_en=1, rom_addr=0xBFC00000; ready=1; response 1 cycle after acceptance with rdata=0x24010001.
  - Response: stall high 3 cycles; bus_addr=0xBFC00000, bus_we=0; DONE cycle has stall=0 and rom_read_data=0x24010001; stall_cycles=3.
- Load plus fetch:
  - Stimulus: ram_en=1, ram_write_en=0, ram_addr=0x80000010, response rdata=0xDEADBEEF; fetch at 0xBFC00004 returns 0x8C020010.
  - Response: data request issued first; ram_read_data=0xDEADBEEF and rom_read_data=0x8C020010 in DONE.
- Byte store with backpressure:
  - Stimulus: ram_write_en=4'b0010, wdata=0x0000AB00; bus_req_ready low for 4 cycles.
  - Response: bus_req_valid held; addr/we/wdata stable all 4 cycles; ram_read_data unchanged after the ack.
- Reset mid-transaction:
  - Stimulus: assert rst=0 in D_WAIT, asynchronously between edges.
  - Response: bus_req_valid=0, state IDLE, stall_cycles=0 immediately; after release a fresh fetch completes normally.
- Counter wrap:
  - Stimulus: force stall_cycles=0xFFFFFFFE, then one 3-stall fetch.
  - Response: counter reads 0x00000001.
- Idle:
  - Stimulus: rom_en=ram_en=0 for 10 cycles.
  - Response: stall=0, bus_req_valid=0, counter unchanged.
